fetch_unit: RTL and testbench

//  Instruction fetch controller on the consumer side of the pc register. Reads the

---
 rtl/fetch_unit.sv | 217 +++++++++++++++++++++
 tb/tb_fetch_unit.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch controller on the consumer side of the pc register.
//   It reads the current pc and run flag, issues word reads to instruction
//   memory over a req/ack handshake, and buffers fetched words in a small FIFO
//   for decode. It also drives the next pc and run flag back into the pc
//   register, covering sequential +PC_STEP, redirect and halt.
//
//   Optional feature macro: FETCH_ALIGN_CHECK_EN
//     defined   : a misaligned redirect target (target[1:0] != 0) sets a sticky
//                 o_fault. The pc is not updated, the FIFO is flushed and the
//                 FSM enters HALTED.
//     undefined : target[1:0] is forced to 0 and o_fault stays 0.
//
//   Ports
//     i_clk, i_rst                  clock (rising edge) / async active-high reset
//     i_pc, i_run                   current pc and run flag from the pc register
//     o_pc_next, o_run_next         next pc (combinational) / run flag (registered)
//     o_mem_req, o_mem_addr         registered read request and word address
//     i_mem_ack, i_mem_data         read completion and returned instruction word
//     o_inst_valid, o_inst,
//     o_inst_pc, i_inst_ready       FIFO head towards decode (pop on valid&ready)
//     i_redirect, i_redirect_pc     single-cycle redirect pulse and its target
//     i_halt                        level request to stop fetching
//     o_fault                       sticky misaligned-redirect flag
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter int          DEPTH   = 2,
    parameter logic [31:0] PC_STEP = 32'd4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_pc,
    input  logic        i_run,
    output logic [31:0] o_pc_next,
    output logic        o_run_next,
    output logic        o_mem_req,
    output logic [31:0] o_mem_addr,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_data,
    output logic        o_inst_valid,
    output logic [31:0] o_inst,
    output logic [31:0] o_inst_pc,
    input  logic        i_inst_ready,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    input  logic        i_halt,
    output logic        o_fault
);

    localparam int              AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int              CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t        state_r, state_s;
    logic          squash_r, squash_s;
    logic          req_s;
    logic [31:0]   addr_s;
    logic          fault_r;
    logic [31:0]   pc_next_s;
    logic          push_s, pop_s, flush_s;
    logic          misalign_s;
    logic [31:0]   target_s;

    logic [31:0]   fifo_pc_r   [DEPTH];
    logic [31:0]   fifo_inst_r [DEPTH];
    logic [AW-1:0] wr_ptr_r, rd_ptr_r, wr_ptr_s, rd_ptr_s;
    logic [CW-1:0] count_r, count_s;

`ifdef FETCH_ALIGN_CHECK_EN
    assign misalign_s = i_redirect && (i_redirect_pc[1:0] != 2'b00);
    assign target_s   = i_redirect_pc;
`else
    logic redirect_lsb_unused_s;
    assign redirect_lsb_unused_s = ^i_redirect_pc[1:0];
    assign misalign_s = 1'b0;
    assign target_s   = {i_redirect_pc[31:2], 2'b00};
`endif

    // Any redirect, aligned or not, throws away everything buffered.
    assign flush_s   = i_redirect;
    assign pop_s     = o_inst_valid && i_inst_ready;
    assign o_pc_next = pc_next_s;
    assign o_fault   = fault_r;
    assign o_inst    = fifo_inst_r[rd_ptr_r];
    assign o_inst_pc = fifo_pc_r[rd_ptr_r];

    // Next-state, request and next-pc decode for the fetch FSM.
    always_comb begin
        state_s   = state_r;
        squash_s  = squash_r;
        req_s     = o_mem_req;
        addr_s    = o_mem_addr;
        push_s    = 1'b0;
        pc_next_s = i_pc;
        case (state_r)
            ST_IDLE: begin
                if (misalign_s || i_halt) begin
                    state_s = ST_HALTED;
                end else if (i_run && !i_redirect && (count_r < DEPTH_C)) begin
                    // i_pc is stale in a redirect cycle, so issue only once it has settled.
                    state_s = ST_REQ;
                    req_s   = 1'b1;
                    addr_s  = {i_pc[31:2], 2'b00};
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (misalign_s) begin
                    state_s  = ST_HALTED;
                    req_s    = 1'b0;
                    squash_s = 1'b0;
                end else if (i_mem_ack) begin
                    req_s    = 1'b0;
                    squash_s = 1'b0;
                    // A squashed or same-cycle-redirected ack belongs to a dead path.
                    if (!squash_r && !i_redirect) begin
                        push_s    = 1'b1;
                        pc_next_s = i_pc + PC_STEP;
                    end else begin
                        push_s = 1'b0;
                    end
                    state_s = i_halt ? ST_HALTED : ST_IDLE;
                end else if (i_redirect) begin
                    squash_s = 1'b1;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_HALTED: begin
                req_s = 1'b0;
            end
            default: begin
                state_s  = ST_IDLE;
                req_s    = 1'b0;
                squash_s = 1'b0;
            end
        endcase
        // An aligned redirect overrides every other pc source.
        if (i_redirect && !misalign_s) begin
            pc_next_s = target_s;
        end else begin
            pc_next_s = pc_next_s;
        end
    end

    // FIFO pointer and occupancy update; flush wins over push/pop.
    always_comb begin
        wr_ptr_s = wr_ptr_r;
        rd_ptr_s = rd_ptr_r;
        count_s  = count_r;
        if (flush_s) begin
            wr_ptr_s = {AW{1'b0}};
            rd_ptr_s = {AW{1'b0}};
            count_s  = {CW{1'b0}};
        end else begin
            if (push_s) wr_ptr_s = wr_ptr_r + AW'(1);
            else        wr_ptr_s = wr_ptr_r;
            if (pop_s)  rd_ptr_s = rd_ptr_r + AW'(1);
            else        rd_ptr_s = rd_ptr_r;
            if (push_s && !pop_s)      count_s = count_r + CW'(1);
            else if (!push_s && pop_s) count_s = count_r - CW'(1);
            else                       count_s = count_r;
        end
    end

    // Control registers: FSM, squash, request, run flag, fault and FIFO state.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r      <= ST_IDLE;
            squash_r     <= 1'b0;
            o_mem_req    <= 1'b0;
            o_mem_addr   <= 32'h0000_0000;
            o_run_next   <= 1'b1;
            fault_r      <= 1'b0;
            wr_ptr_r     <= {AW{1'b0}};
            rd_ptr_r     <= {AW{1'b0}};
            count_r      <= {CW{1'b0}};
            o_inst_valid <= 1'b0;
        end else begin
            state_r      <= state_s;
            squash_r     <= squash_s;
            o_mem_req    <= req_s;
            o_mem_addr   <= addr_s;
            o_run_next   <= (state_s != ST_HALTED);
            fault_r      <= fault_r | misalign_s;
            wr_ptr_r     <= wr_ptr_s;
            rd_ptr_r     <= rd_ptr_s;
            count_r      <= count_s;
            o_inst_valid <= (count_s != {CW{1'b0}});
        end
    end

    // FIFO storage: write the accepted {pc, word} pair at the tail.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_pc_r[i]   <= 32'h0000_0000;
                fifo_inst_r[i] <= 32'h0000_0000;
            end
        end else if (push_s && !flush_s) begin
            fifo_pc_r[wr_ptr_r]   <= i_pc;
            fifo_inst_r[wr_ptr_r] <= i_mem_data;
        end else begin
            fifo_pc_r[wr_ptr_r]   <= fifo_pc_r[wr_ptr_r];
            fifo_inst_r[wr_ptr_r] <= fifo_inst_r[wr_ptr_r];
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pc_r, pc_init = 32'h0;
    logic        run = 1'b0, halt = 1'b0, redirect = 1'b0, ready = 1'b0, ack = 1'b0;
    logic [31:0] redirect_pc = 32'h0, mem_data = 32'h0;
    logic [31:0] pc_next, mem_addr, inst, inst_pc;
    logic        run_next, mem_req, inst_valid, fault;

    int tests_run = 0, tests_failed = 0;
    int ack_count = 0, ack_dly = 0;
    bit ack_en = 1'b0;
    logic [31:0] exp_addr_q[$];
    logic [63:0] exp_inst_q[$];

    always #5 clk = ~clk;

    // Environment pc register fed by o_pc_next.
    always @(posedge clk or posedge rst) begin
        if (rst) pc_r <= pc_init;
        else     pc_r <= pc_next;
    end

    fetch_unit #(.DEPTH(2), .PC_STEP(32'd4)) dut (
        .i_clk(clk), .i_rst(rst), .i_pc(pc_r), .i_run(run),
        .o_pc_next(pc_next), .o_run_next(run_next),
        .o_mem_req(mem_req), .o_mem_addr(mem_addr),
        .i_mem_ack(ack), .i_mem_data(mem_data),
        .o_inst_valid(inst_valid), .o_inst(inst), .o_inst_pc(inst_pc),
        .i_inst_ready(ready), .i_redirect(redirect), .i_redirect_pc(redirect_pc),
        .i_halt(halt), .o_fault(fault)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic exp_inst(input logic [31:0] a);
        exp_inst_q.push_back({a, mem_word(a)});
    endtask

    // Inputs change at negedge+2; monitor samples at negedge+3.
    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic wait_acks(input int n, input string name);
        int k = 0;
        while (ack_count < n && k < 200) begin
            step();
            k++;
        end
        tests_run++;
        if (ack_count < n) begin
            tests_failed++;
            $display("FAIL %s: got %0d acks expected %0d (timeout)", name, ack_count, n);
        end
    endtask

    task automatic wait_req(input string name);
        int k = 0;
        while (!mem_req && k < 200) begin
            step();
            k++;
        end
        check(name, {31'h0, mem_req}, 32'h1);
    endtask

    task automatic reset_dut(input logic [31:0] pc0);
        step();
        pc_init  = pc0;
        run      = 1'b0;
        halt     = 1'b0;
        redirect = 1'b0;
        ready    = 1'b0;
        ack_en   = 1'b0;
        ack_dly  = 0;
        rst      = 1'b1;
        step();
        ack_count = 0;
        step();
        check("rst_req",      {31'h0, mem_req},    32'h0);
        check("rst_addr",     mem_addr,            32'h0);
        check("rst_valid",    {31'h0, inst_valid}, 32'h0);
        check("rst_run_next", {31'h0, run_next},   32'h1);
        check("rst_fault",    {31'h0, fault},      32'h0);
        check("rst_pc_next",  pc_next,             pc0);
        rst = 1'b0;
    endtask

    task automatic end_test(input string name);
        repeat (4) step();
        check({name, "_addr_q_empty"}, exp_addr_q.size(), 32'h0);
        check({name, "_inst_q_empty"}, exp_inst_q.size(), 32'h0);
        exp_addr_q.delete();
        exp_inst_q.delete();
    endtask

    // Memory responder: acks a request after ack_dly extra cycles when enabled.
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (rst || ack) begin
                ack = 1'b0;
                cnt = 0;
            end else if (mem_req && ack_en) begin
                if (cnt >= ack_dly) begin
                    ack      = 1'b1;
                    mem_data = mem_word(mem_addr);
                    ack_count++;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Monitor: new requests and decode pops are checked against the queues.
    initial begin
        logic        req_prev;
        logic [31:0] ea;
        logic [63:0] ei;
        req_prev = 1'b0;
        forever begin
            @(negedge clk);
            #3;
            if (rst) begin
                req_prev = 1'b0;
            end else begin
                if (mem_req && !req_prev) begin
                    if (exp_addr_q.size() == 0) begin
                        tests_run++;
                        tests_failed++;
                        $display("FAIL req_unexpected: got addr %h expected no request", mem_addr);
                    end else begin
                        ea = exp_addr_q.pop_front();
                        check("req_addr", mem_addr, ea);
                    end
                end
                req_prev = mem_req;
                if (inst_valid && ready) begin
                    if (exp_inst_q.size() == 0) begin
                        tests_run++;
                        tests_failed++;
                        $display("FAIL inst_unexpected: got pc %h inst %h expected none", inst_pc, inst);
                    end else begin
                        ei = exp_inst_q.pop_front();
                        check("inst_pc", inst_pc, ei[63:32]);
                        check("inst",    inst,    ei[31:0]);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // T1: sequential fetch 0,4,8 with immediate acks.
        reset_dut(32'h0);
        ready = 1'b1; run = 1'b1; ack_en = 1'b1;
        exp_addr_q.push_back(32'h0); exp_addr_q.push_back(32'h4); exp_addr_q.push_back(32'h8);
        exp_inst(32'h0); exp_inst(32'h4); exp_inst(32'h8);
        wait_acks(3, "t1_acks");
        run = 1'b0;
        end_test("t1");

        // T2: FIFO full stalls fetch, resume after decode drains.
        reset_dut(32'h0);
        run = 1'b1; ack_en = 1'b1;
        exp_addr_q.push_back(32'h0); exp_addr_q.push_back(32'h4); exp_addr_q.push_back(32'h8);
        exp_inst(32'h0); exp_inst(32'h4); exp_inst(32'h8);
        wait_acks(2, "t2_fill");
        repeat (6) step();
        check("t2_ack_count", ack_count, 32'd2);
        check("t2_req_idle", {31'h0, mem_req}, 32'h0);
        check("t2_valid", {31'h0, inst_valid}, 32'h1);
        ready = 1'b1;
        wait_acks(3, "t2_resume");
        run = 1'b0;
        end_test("t2");

        // T3: redirect while request to 0x8 is pending; late ack discarded.
        reset_dut(32'h8);
        ready = 1'b1; run = 1'b1;
        exp_addr_q.push_back(32'h8); exp_addr_q.push_back(32'h100);
        exp_inst(32'h100);
        wait_req("t3_req");
        redirect = 1'b1; redirect_pc = 32'h100;
        step();
        redirect = 1'b0;
        check("t3_req_held", mem_addr, 32'h8);
        step();
        ack_en = 1'b1;
        wait_acks(1, "t3_ack1");
        check("t3_pc_no_adv", pc_next, 32'h100);
        step();
        check("t3_fifo_empty", {31'h0, inst_valid}, 32'h0);
        wait_acks(2, "t3_ack2");
        run = 1'b0;
        end_test("t3");

        // T4: pc wraps from 0xFFFFFFFC to 0.
        reset_dut(32'hFFFF_FFFC);
        ready = 1'b1; run = 1'b1; ack_en = 1'b1;
        exp_addr_q.push_back(32'hFFFF_FFFC); exp_addr_q.push_back(32'h0);
        exp_inst(32'hFFFF_FFFC); exp_inst(32'h0);
        wait_acks(1, "t4_ack1");
        check("t4_pc_wrap", pc_next, 32'h0);
        wait_acks(2, "t4_ack2");
        run = 1'b0;
        end_test("t4");

        // T5: halt during REQ, ack still pushed, then halted and draining.
        reset_dut(32'h20);
        run = 1'b1;
        exp_addr_q.push_back(32'h20);
        exp_inst(32'h20);
        wait_req("t5_req");
        halt = 1'b1;
        step();
        check("t5_run_before", {31'h0, run_next}, 32'h1);
        ack_en = 1'b1;
        wait_acks(1, "t5_ack");
        check("t5_pc_adv", pc_next, 32'h24);
        step();
        check("t5_run_next", {31'h0, run_next}, 32'h0);
        check("t5_req_drop", {31'h0, mem_req}, 32'h0);
        check("t5_valid", {31'h0, inst_valid}, 32'h1);
        halt = 1'b0;
        repeat (5) step();
        check("t5_no_req", {31'h0, mem_req}, 32'h0);
        ready = 1'b1;
        repeat (3) step();
        check("t5_drained", {31'h0, inst_valid}, 32'h0);
        check("t5_still_halted", {31'h0, run_next}, 32'h0);
        end_test("t5");

        // T6: misaligned redirect target 0x102.
        reset_dut(32'h0);
        ready = 1'b1; ack_en = 1'b1;
        redirect = 1'b1; redirect_pc = 32'h102;
        #1;
`ifdef FETCH_ALIGN_CHECK_EN
        check("t6_pc_hold", pc_next, 32'h0);
        step();
        redirect = 1'b0;
        check("t6_fault", {31'h0, fault}, 32'h1);
        check("t6_halted", {31'h0, run_next}, 32'h0);
        run = 1'b1;
        repeat (4) step();
        check("t6_no_req", {31'h0, mem_req}, 32'h0);
`else
        check("t6_pc_aligned", pc_next, 32'h100);
        step();
        redirect = 1'b0;
        check("t6_no_fault", {31'h0, fault}, 32'h0);
        exp_addr_q.push_back(32'h100);
        exp_inst(32'h100);
        run = 1'b1;
        wait_acks(1, "t6_ack");
        run = 1'b0;
`endif
        end_test("t6");

        // T7: redirect flushes a full FIFO.
        reset_dut(32'h0);
        run = 1'b1; ack_en = 1'b1;
        exp_addr_q.push_back(32'h0); exp_addr_q.push_back(32'h4); exp_addr_q.push_back(32'h80);
        exp_inst(32'h80);
        wait_acks(2, "t7_fill");
        step(); step();
        check("t7_full", {31'h0, inst_valid}, 32'h1);
        redirect = 1'b1; redirect_pc = 32'h80;
        step();
        redirect = 1'b0;
        check("t7_flush", {31'h0, inst_valid}, 32'h0);
        ready = 1'b1;
        wait_acks(3, "t7_ack3");
        run = 1'b0;
        end_test("t7");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
